// File: rtl/dvi_pkg.sv
// Shared DVI definitions: TMDS symbol type,
// control-period codes and a byte popcount.
package dvi_pkg;

  typedef logic [9:0] tmds_sym_t;

  localparam tmds_sym_t CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount(
    input logic [7:0] v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// Single-channel DVI TMDS encoder: 8b/10b with
// transition minimisation and running DC balance.
module tmds_encoder
  import dvi_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    de,
  input  logic [7:0]              d,
  input  logic [1:0]              c,
  output tmds_sym_t               q,
  output logic signed [CNT_W-1:0] disp
);

  localparam logic signed [CNT_W-1:0] ZERO = '0;
  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm;

  logic [8:0] qm_r;
  logic       de_r;
  logic [1:0] c_r;

  logic [3:0]              n1;
  logic signed [CNT_W-1:0] n1_s;
  logic signed [CNT_W-1:0] bal;
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nx;
  logic                    case_a;
  logic                    case_b;
  tmds_sym_t               sym_nx;

  always_comb begin
    qm = '0;
    n1d = popcount(d);
    use_xnor = (n1d > 4'd4) ||
               (n1d == 4'd4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i])
                       : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm_r <= '0;
      de_r <= 1'b0;
      c_r  <= 2'b00;
    end else begin
      qm_r <= qm;
      de_r <= de;
      c_r  <= c;
    end
  end

  // bal = n1 - n0 = 2*n1 - 8
  always_comb begin
    n1 = popcount(qm_r[7:0]);
    n1_s = CNT_W'(n1);
    bal = (n1_s <<< 1) - EIGHT;
    case_a = (cnt == ZERO) || (bal == ZERO);
    case_b = (cnt > ZERO && bal > ZERO) ||
             (cnt < ZERO && bal < ZERO);
    sym_nx = CTRL_00;
    cnt_nx = ZERO;
    if (de_r) begin
      unique case (1'b1)
        case_a: begin
          sym_nx = {~qm_r[8], qm_r[8],
                    qm_r[8] ? qm_r[7:0]
                            : ~qm_r[7:0]};
          cnt_nx = qm_r[8] ? cnt + bal
                           : cnt - bal;
        end
        case_b: begin
          sym_nx = {1'b1, qm_r[8], ~qm_r[7:0]};
          cnt_nx = cnt + (qm_r[8] ? TWO : ZERO)
                 - bal;
        end
        default: begin
          sym_nx = {1'b0, qm_r[8], qm_r[7:0]};
          cnt_nx = cnt + bal
                 - (qm_r[8] ? ZERO : TWO);
        end
      endcase
    end else begin
      unique case (c_r)
        2'b00: sym_nx = CTRL_00;
        2'b01: sym_nx = CTRL_01;
        2'b10: sym_nx = CTRL_10;
        2'b11: sym_nx = CTRL_11;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= CTRL_00;
      cnt <= ZERO;
    end else begin
      q   <= sym_nx;
      cnt <= cnt_nx;
    end
  end

  assign disp = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: vector table, random
// stream against a reference model, reset cases.
module tb_tmds_encoder;
  import dvi_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              de;
  logic [7:0]        d;
  logic [1:0]        c;
  tmds_sym_t         q;
  logic signed [4:0] disp;

  always #5 clk = ~clk;

  tmds_encoder #(.CNT_W(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .de   (de),
    .d    (d),
    .c    (c),
    .q    (q),
    .disp (disp)
  );

  typedef struct {
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
    logic [9:0] q;
    int         disp;
  } vec_t;

  typedef struct {
    logic [9:0] q;
    int         disp;
    logic       de;
    logic [7:0] d;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   mcnt = 0;

  task automatic chk(
    input string tag,
    input logic signed [31:0] act,
    input logic signed [31:0] req
  );
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (%0h) want %0d (%0h)",
               tag, act, act, req, req);
    end
  endtask

  function automatic exp_t model(
    input logic       de_i,
    input logic [7:0] d_i,
    input logic [1:0] c_i
  );
    exp_t r;
    logic [8:0] m;
    int ones, n1, n0;
    logic xn;
    r.de = de_i;
    r.d = d_i;
    r.tag = "";
    m = '0;
    if (!de_i) begin
      mcnt = 0;
      case (c_i)
        2'b00: r.q = 10'h354;
        2'b01: r.q = 10'h0AB;
        2'b10: r.q = 10'h154;
        default: r.q = 10'h2AB;
      endcase
    end else begin
      ones = $countones(d_i);
      xn = (ones > 4) || (ones == 4 && !d_i[0]);
      m[0] = d_i[0];
      for (int i = 1; i < 8; i++)
        m[i] = xn ? ~(m[i-1] ^ d_i[i])
                  : (m[i-1] ^ d_i[i]);
      m[8] = !xn;
      n1 = $countones(m[7:0]);
      n0 = 8 - n1;
      if (mcnt == 0 || n1 == n0) begin
        r.q = {~m[8], m[8],
               m[8] ? m[7:0] : ~m[7:0]};
        mcnt += m[8] ? (n1 - n0) : (n0 - n1);
      end else if ((mcnt > 0 && n1 > n0) ||
                   (mcnt < 0 && n0 > n1)) begin
        r.q = {1'b1, m[8], ~m[7:0]};
        mcnt += (m[8] ? 2 : 0) + n0 - n1;
      end else begin
        r.q = {1'b0, m[8], m[7:0]};
        mcnt += n1 - n0 - (m[8] ? 0 : 2);
      end
    end
    r.disp = mcnt;
    return r;
  endfunction

  task automatic step(
    input logic       de_i,
    input logic [7:0] d_i,
    input logic [1:0] c_i,
    input bit         use_tab,
    input logic [9:0] tq,
    input int         td,
    input string      tag
  );
    exp_t e, x;
    logic [7:0] t, dd;
    e = model(de_i, d_i, c_i);
    if (use_tab) begin
      e.q = tq;
      e.disp = td;
    end
    e.tag = tag;
    sb.push_back(e);
    de = de_i;
    d = d_i;
    c = c_i;
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      x = sb.pop_front();
      chk({x.tag, " q"}, 32'(q), 32'(x.q));
      chk({x.tag, " disp"}, 32'(disp), x.disp);
      chk({x.tag, " bound"},
          32'(disp >= -8 && disp <= 8), 1);
      if (x.de) begin
        t = q[9] ? ~q[7:0] : q[7:0];
        dd[0] = t[0];
        for (int i = 1; i < 8; i++)
          dd[i] = q[8] ? (t[i] ^ t[i-1])
                       : ~(t[i] ^ t[i-1]);
        chk({x.tag, " decode"}, 32'(dd), 32'(x.d));
      end
    end
  endtask

  task automatic prime();
    exp_t p;
    p.q = CTRL_00;
    p.disp = 0;
    p.de = 1'b0;
    p.d = '0;
    p.tag = "post_rst";
    sb.delete();
    sb.push_back(p);
    mcnt = 0;
  endtask

  vec_t tab[12];

  initial begin
    tab = '{
      '{1'b0, 8'h00, 2'b00, 10'h354, 0},
      '{1'b0, 8'h00, 2'b00, 10'h354, 0},
      '{1'b0, 8'h5A, 2'b01, 10'h0AB, 0},
      '{1'b0, 8'hA5, 2'b10, 10'h154, 0},
      '{1'b0, 8'h00, 2'b11, 10'h2AB, 0},
      '{1'b0, 8'h00, 2'b00, 10'h354, 0},
      '{1'b1, 8'h00, 2'b00, 10'h100, -8},
      '{1'b1, 8'h00, 2'b11, 10'h3FF, 2},
      '{1'b0, 8'h00, 2'b00, 10'h354, 0},
      '{1'b1, 8'hFF, 2'b00, 10'h200, -8},
      '{1'b0, 8'h00, 2'b00, 10'h354, 0},
      '{1'b0, 8'h00, 2'b00, 10'h354, 0}
    };
    rst = 1'b1;
    de = 1'b0;
    d = '0;
    c = 2'b00;
    #12;
    chk("in_rst q", 32'(q), 32'(CTRL_00));
    chk("in_rst disp", 32'(disp), 0);
    @(negedge clk);
    rst = 1'b0;
    prime();

    foreach (tab[i])
      step(tab[i].de, tab[i].d, tab[i].c, 1'b1,
           tab[i].q, tab[i].disp,
           $sformatf("tab%0d", i));

    for (int i = 0; i < 10000; i++)
      step(1'b1, 8'($urandom), 2'($urandom),
           1'b0, '0, 0, "rand");
    step(1'b0, 8'h00, 2'b00, 1'b0, '0, 0, "flush");

    // mid-line reset with nonzero disparity
    step(1'b1, 8'h00, 2'b00, 1'b0, '0, 0, "pre");
    step(1'b1, 8'h00, 2'b00, 1'b0, '0, 0, "pre");
    #2;
    chk("pre_rst disp nonzero",
        32'(disp != 0), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst q", 32'(q), 32'(CTRL_00));
    chk("mid_rst disp", 32'(disp), 0);
    @(negedge clk);
    rst = 1'b0;
    prime();
    step(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8,
         "after_rst");
    step(1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF, 2,
         "after_rst2");
    step(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0,
         "end_blank");
    step(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0,
         "end_blank2");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
